// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA pattern pipeline
package vga_pkg;

  localparam int POS_W = 10;
  localparam int COL_W = 2;

  typedef enum logic [1:0] {
    MODE_SCROLL = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_BARS   = 2'd3
  } mode_t;

  // TinyVGA PMOD bit positions within pmod_out
  localparam int PMOD_R1 = 0;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_VS = 3;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_HS = 7;

endpackage

// File: rtl/vga_pattern_colour.sv
// rtl/vga_pattern_colour.sv - combinational test-pattern colour lookup
module vga_pattern_colour
  import vga_pkg::*;
(
  input  mode_t             mode,
  input  logic [POS_W-1:0]  mx,
  input  logic [POS_W-1:0]  y,
  input  logic [2:0]        bar,
  output logic [COL_W-1:0]  r,
  output logic [COL_W-1:0]  g,
  output logic [COL_W-1:0]  b
);

  // Position bits no pattern looks at
  logic unused_bits;
  assign unused_bits = ^{mx[3:0], y[9], y[6], y[3], y[1:0]};

  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    case (mode)
      MODE_SCROLL: begin
        r = {mx[5], y[2]};
        g = {mx[6], y[2]};
        b = {mx[7], y[5]};
      end
      MODE_CHECK: begin
        r = {mx[5] ^ y[5], mx[4] ^ y[4]};
        g = r;
        b = r;
      end
      MODE_GRAD: begin
        r = mx[9:8];
        g = mx[8:7];
        b = y[8:7];
      end
      MODE_BARS: begin
        r = {2{bar[2]}};
        g = {2{bar[1]}};
        b = {2{bar[0]}};
      end
      default: begin
        r = '0;
        g = '0;
        b = '0;
      end
    endcase
  end

endmodule

// File: rtl/vga_pattern_pipeline.sv
// rtl/vga_pattern_pipeline.sv - frame tick, scroll state and 2-stage colour pipeline to TinyVGA
module vga_pattern_pipeline
  import vga_pkg::*;
#(
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   FC_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              display_on,
  input  logic [POS_W-1:0]  hpos,
  input  logic [POS_W-1:0]  vpos,
  input  logic [1:0]        mode,
  input  logic [2:0]        speed,
  input  logic              pause,
  output logic [COL_W-1:0]  r,
  output logic [COL_W-1:0]  g,
  output logic [COL_W-1:0]  b,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic [7:0]        pmod_out,
  output logic [FC_W-1:0]   frame_count
);

  logic             vsync_q;
  logic             tick;
  logic [POS_W-1:0] offset;
  mode_t            active_mode;

  logic [POS_W-1:0] s1_mx;
  logic [POS_W-1:0] s1_y;
  logic             s1_de;
  logic             s1_hs;
  logic             s1_vs;
  logic [2:0]       s1_bar;
  mode_t            s1_mode;

  logic [COL_W-1:0] col_r;
  logic [COL_W-1:0] col_g;
  logic [COL_W-1:0] col_b;

  assign tick = (vsync_q != VSYNC_POL) && (vsync_in == VSYNC_POL);

  // Frame-rate state, advanced only on the asserting edge of vsync
  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q     <= ~VSYNC_POL;
      offset      <= '0;
      frame_count <= '0;
      active_mode <= MODE_SCROLL;
    end else begin
      vsync_q <= vsync_in;
      if (tick) begin
        frame_count <= frame_count + 1'b1;
        active_mode <= mode_t'(mode);
        if (!pause) begin
          offset <= offset + {7'd0, speed};
        end
      end
    end
  end

  // S1 captures mode alongside the pixel so each pixel sees a consistent mode/offset pair
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_mx   <= '0;
      s1_y    <= '0;
      s1_de   <= 1'b0;
      s1_hs   <= ~HSYNC_POL;
      s1_vs   <= ~VSYNC_POL;
      s1_bar  <= '0;
      s1_mode <= MODE_SCROLL;
    end else begin
      s1_mx   <= hpos + offset;
      s1_y    <= vpos;
      s1_de   <= display_on;
      s1_hs   <= hsync_in;
      s1_vs   <= vsync_in;
      s1_bar  <= hpos[9:7];
      s1_mode <= active_mode;
    end
  end

  vga_pattern_colour u_colour (
    .mode (s1_mode),
    .mx   (s1_mx),
    .y    (s1_y),
    .bar  (s1_bar),
    .r    (col_r),
    .g    (col_g),
    .b    (col_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r         <= '0;
      g         <= '0;
      b         <= '0;
      hsync_out <= ~HSYNC_POL;
      vsync_out <= ~VSYNC_POL;
    end else begin
      r         <= s1_de ? col_r : '0;
      g         <= s1_de ? col_g : '0;
      b         <= s1_de ? col_b : '0;
      hsync_out <= s1_hs;
      vsync_out <= s1_vs;
    end
  end

  always_comb begin
    pmod_out          = '0;
    pmod_out[PMOD_HS] = hsync_out;
    pmod_out[PMOD_B0] = b[0];
    pmod_out[PMOD_G0] = g[0];
    pmod_out[PMOD_R0] = r[0];
    pmod_out[PMOD_VS] = vsync_out;
    pmod_out[PMOD_B1] = b[1];
    pmod_out[PMOD_G1] = g[1];
    pmod_out[PMOD_R1] = r[1];
  end

endmodule

// File: tb/tb_vga_pattern_pipeline.sv
// tb/tb_vga_pattern_pipeline.sv - scoreboard bench with a frame-level reference model
module tb_vga_pattern_pipeline;

  localparam logic HP   = 1'b0;
  localparam logic VP   = 1'b0;
  localparam int   FCW  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync_in, vsync_in, display_on;
  logic [9:0] hpos, vpos;
  logic [1:0] mode;
  logic [2:0] speed;
  logic       pause;
  logic [1:0] r, g, b;
  logic       hsync_out, vsync_out;
  logic [7:0] pmod_out;
  logic [FCW-1:0] frame_count;

  always #5 clk = ~clk;

  vga_pattern_pipeline #(
    .HSYNC_POL (HP),
    .VSYNC_POL (VP),
    .FC_W      (FCW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .mode        (mode),
    .speed       (speed),
    .pause       (pause),
    .r           (r),
    .g           (g),
    .b           (b),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .pmod_out    (pmod_out),
    .frame_count (frame_count)
  );

  typedef struct {
    int   due;
    logic [1:0] r, g, b;
    logic hs, vs;
    int   fc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: frames seen, scroll offset, latched mode, previous vsync level
  int   m_off, m_fc, m_mode;
  logic m_vprev;
  exp_t pend;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic bt(input int v, input int i);
    return logic'((v >> i) & 1);
  endfunction

  function automatic exp_t idle_pix();
    exp_t e;
    e.due = 0; e.r = 2'b00; e.g = 2'b00; e.b = 2'b00;
    e.hs = ~HP; e.vs = ~VP; e.fc = 0;
    return e;
  endfunction

  function automatic exp_t ref_pix(input int hp, input int vp, input int md, input int off,
                                   input logic de, input logic hs, input logic vs);
    exp_t e;
    int   mx, bar;
    e = idle_pix();
    e.hs = hs;
    e.vs = vs;
    mx  = (hp + off) % 1024;
    bar = hp / 128;
    case (md)
      0: begin
        e.r = {bt(mx, 5), bt(vp, 2)};
        e.g = {bt(mx, 6), bt(vp, 2)};
        e.b = {bt(mx, 7), bt(vp, 5)};
      end
      1: begin
        e.r = {bt(mx, 5) ^ bt(vp, 5), bt(mx, 4) ^ bt(vp, 4)};
        e.g = e.r;
        e.b = e.r;
      end
      2: begin
        e.r = 2'((mx / 256) % 4);
        e.g = 2'((mx / 128) % 4);
        e.b = 2'((vp / 128) % 4);
      end
      default: begin
        e.r = {2{bt(bar, 2)}};
        e.g = {2{bt(bar, 1)}};
        e.b = {2{bt(bar, 0)}};
      end
    endcase
    if (!de) begin
      e.r = 2'b00; e.g = 2'b00; e.b = 2'b00;
    end
    return e;
  endfunction

  task automatic drive(input logic rst, input logic hs, input logic vs, input logic de,
                       input int hp, input int vp, input int md, input int sp, input logic pz);
    exp_t e;
    logic tk;
    @(posedge clk);
    #1;
    reset = rst; hsync_in = hs; vsync_in = vs; display_on = de;
    hpos = 10'(hp); vpos = 10'(vp); mode = 2'(md); speed = 3'(sp); pause = pz;
    // Output after the sampling edge shows the previous cycle's pixel unless reset clears it
    e = rst ? idle_pix() : pend;
    e.due = cyc + 1;
    pend = rst ? idle_pix() : ref_pix(hp, vp, m_mode, m_off, de, hs, vs);
    if (rst) begin
      m_off = 0; m_fc = 0; m_mode = 0; m_vprev = ~VP;
    end else begin
      tk = (m_vprev != VP) && (vs == VP);
      if (tk) begin
        m_fc   = (m_fc + 1) % (1 << FCW);
        m_mode = md;
        if (!pz) m_off = (m_off + sp) % 1024;
      end
      m_vprev = vs;
    end
    e.fc = m_fc;
    q.push_back(e);
  endtask

  task automatic rand_pix(input logic rst, input logic vs, input int md, input int sp, input logic pz);
    int hp;
    case ($urandom_range(0, 3))
      0: hp = 64;
      1: hp = 384;
      default: hp = $urandom_range(0, 1023);
    endcase
    drive(rst, logic'($urandom_range(0, 1)), vs, logic'($urandom_range(0, 3) != 0),
          hp, $urandom_range(0, 1023), md, sp, pz);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] pm;
    if (q.size() > 0 && q[0].due <= cyc) begin
      e  = q.pop_front();
      pm = {e.hs, e.b[0], e.g[0], e.r[0], e.vs, e.b[1], e.g[1], e.r[1]};
      n_vec++;
      if (e.due != cyc || r !== e.r || g !== e.g || b !== e.b || hsync_out !== e.hs ||
          vsync_out !== e.vs || pmod_out !== pm || frame_count !== FCW'(e.fc)) begin
        n_err++;
        $display("FAIL pixel cyc=%0d due=%0d: got r=%b g=%b b=%b hs=%b vs=%b pmod=%b fc=%0d, want r=%b g=%b b=%b hs=%b vs=%b pmod=%b fc=%0d",
                 cyc, e.due, r, g, b, hsync_out, vsync_out, pmod_out, frame_count,
                 e.r, e.g, e.b, e.hs, e.vs, pm, e.fc);
      end
    end
  end

  initial begin
    reset = 1'b1; hsync_in = ~HP; vsync_in = ~VP; display_on = 1'b0;
    hpos = '0; vpos = '0; mode = '0; speed = '0; pause = 1'b0;
    m_off = 0; m_fc = 0; m_mode = 0; m_vprev = ~VP;
    pend = idle_pix();

    // Reset held for three cycles, then idle syncs
    repeat (3) rand_pix(1'b1, ~VP, 0, 0, 1'b0);
    repeat (2) rand_pix(1'b0, ~VP, 0, 3, 1'b0);

    // speed 3, four vsync assertions, then frozen scroll
    for (int f = 0; f < 4; f++) begin
      repeat (2) rand_pix(1'b0, VP, 0, 3, 1'b0);
      repeat (6) rand_pix(1'b0, ~VP, 0, 3, 1'b0);
    end
    for (int f = 0; f < 2; f++) begin
      repeat (2) rand_pix(1'b0, VP, 0, 0, 1'b0);
      repeat (6) rand_pix(1'b0, ~VP, 0, 0, 1'b0);
    end

    // Mode 3 requested mid-frame, takes effect at the following tick
    repeat (8) rand_pix(1'b0, ~VP, 3, 0, 1'b0);
    rand_pix(1'b0, VP, 3, 0, 1'b0);
    repeat (8) rand_pix(1'b0, ~VP, 1, 0, 1'b0);

    // Many fast frames at speed 7: offset and frame counter both wrap
    for (int f = 0; f < 300; f++) begin
      rand_pix(1'b0, VP, $urandom_range(0, 3), 7, 1'b0);
      rand_pix(1'b0, ~VP, $urandom_range(0, 3), 7, 1'b0);
    end

    // Pause over five frames keeps the offset, frame counter still advances
    for (int f = 0; f < 5; f++) begin
      rand_pix(1'b0, VP, 0, $urandom_range(1, 7), 1'b1);
      repeat (4) rand_pix(1'b0, ~VP, 0, $urandom_range(1, 7), 1'b1);
    end

    // Reset coincident with a vsync asserting edge
    repeat (3) rand_pix(1'b0, ~VP, 2, 5, 1'b0);
    rand_pix(1'b1, VP, 2, 5, 1'b0);
    repeat (4) rand_pix(1'b0, ~VP, 2, 5, 1'b0);

    // Fully random traffic with occasional mid-frame resets
    for (int i = 0; i < 800; i++) begin
      rand_pix(logic'($urandom_range(0, 49) == 0),
               ($urandom_range(0, 3) == 0) ? VP : ~VP,
               $urandom_range(0, 3), $urandom_range(0, 7),
               logic'($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected pixels never compared, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
